// File: rtl/monolith_pkg.sv
// Shared types for the Monolith-31 datapath: field element width, modulus and ingress states.
package monolith_pkg;

    localparam int unsigned FELT_W = 31;
    localparam logic [30:0] P      = 31'h7FFFFFFF;

    typedef logic [30:0] felt_t;

    typedef enum logic [2:0] {
        IDLE,
        BEAT2,
        DRAIN,
        RUN,
        OUT
    } ingress_state_t;

endpackage

// File: rtl/monolith_axis_ingress_if.sv
// Plain AXI-Stream bundle; master drives payload/valid, slave drives ready.
interface monolith_axis_ingress_if #(
    parameter int unsigned W = 32
) ();

    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic         tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);

endinterface

// File: rtl/mersenne31_reduce.sv
// Reduces a 32-bit word modulo 2^31-1; a single conditional subtract suffices since lo+hi <= 2^31.
module mersenne31_reduce
    import monolith_pkg::*;
(
    input  logic [31:0] x,
    output felt_t       red_c
);

    localparam logic [31:0] P_EXT = {1'b0, P};

    logic [31:0] sum_c;
    logic [31:0] diff_c;

    always_comb begin
        sum_c  = {1'b0, x[30:0]} + {31'd0, x[31]};
        diff_c = sum_c - P_EXT;
        red_c  = (sum_c >= P_EXT) ? diff_c[30:0] : sum_c[30:0];
    end

endmodule

// File: rtl/monolith_axis_ingress.sv
// Stream front end for monolith_top: packs one or two reduced elements into a job,
// owns the engine go/valid handshake and returns the digest as a single-beat packet.
module monolith_axis_ingress
    import monolith_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned LAT_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    monolith_axis_ingress_if.slave  s_axis,
    monolith_axis_ingress_if.master m_axis,
    output felt_t                 core_in1,
    output felt_t                 core_in2,
    output logic                  core_mode,
    output logic                  core_go,
    input  felt_t                 core_out,
    input  logic                  core_valid,
    output logic [LAT_W-1:0]      last_latency
);

    ingress_state_t state_q, state_d;

    felt_t             in1_q, in1_d;
    felt_t             in2_q, in2_d;
    logic              mode_q, mode_d;
    logic              err_q, err_d;
    logic              go_q, go_d;
    logic              s_rdy_q, s_rdy_d;
    logic              m_vld_q, m_vld_d;
    logic [31:0]       m_data_q, m_data_d;
    logic              m_user_q, m_user_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;

    felt_t             red_c;
    logic              accept_c;
    logic [LAT_W-1:0]  cnt_inc_c;
    logic              timeout_c;

    mersenne31_reduce u_reduce (
        .x     (s_axis.tdata),
        .red_c (red_c)
    );

    always_comb begin
        state_d  = state_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        mode_d   = mode_q;
        err_d    = err_q;
        m_data_d = m_data_q;
        m_user_d = m_user_q;
        lat_d    = lat_q;
        cnt_d    = cnt_q;

        accept_c  = s_axis.tvalid && s_rdy_q;
        cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + LAT_W'(1);
        timeout_c = (32'(cnt_q) >= (TIMEOUT_CYCLES - 32'd1));

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    in1_d  = red_c;
                    in2_d  = '0;
                    mode_d = s_axis.tuser;
                    err_d  = 1'b0;
                    if (!s_axis.tuser) begin
                        if (s_axis.tlast) begin
                            state_d = RUN;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (!s_axis.tlast) begin
                        state_d = BEAT2;
                    end else begin
                        // Short compress packet still runs, with in2 left at zero
                        err_d   = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            BEAT2: begin
                if (accept_c) begin
                    in2_d = red_c;
                    if (s_axis.tlast) begin
                        state_d = RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept_c && s_axis.tlast) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_inc_c;
                if (core_valid) begin
                    m_data_d = {1'b0, core_out};
                    m_user_d = err_q;
                    lat_d    = cnt_q;
                    state_d  = OUT;
                end else if (timeout_c) begin
                    m_data_d = '0;
                    m_user_d = 1'b1;
                    lat_d    = cnt_inc_c;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (m_vld_q && m_axis.tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_d == RUN) && (state_q != RUN)) begin
            cnt_d = '0;
        end

        // Handshake outputs are registered from the next state so they track state_q exactly
        go_d    = (state_d == RUN);
        m_vld_d = (state_d == OUT);
        s_rdy_d = (state_d == IDLE) || (state_d == BEAT2) || (state_d == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            in1_q    <= '0;
            in2_q    <= '0;
            mode_q   <= 1'b0;
            err_q    <= 1'b0;
            go_q     <= 1'b0;
            s_rdy_q  <= 1'b0;
            m_vld_q  <= 1'b0;
            m_data_q <= '0;
            m_user_q <= 1'b0;
            lat_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
            go_q     <= go_d;
            s_rdy_q  <= s_rdy_d;
            m_vld_q  <= m_vld_d;
            m_data_q <= m_data_d;
            m_user_q <= m_user_d;
            lat_q    <= lat_d;
            cnt_q    <= cnt_d;
        end
    end

    assign s_axis.tready = s_rdy_q;
    assign m_axis.tvalid = m_vld_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tuser  = m_user_q;
    assign m_axis.tlast  = 1'b1;
    assign core_in1      = in1_q;
    assign core_in2      = in2_q;
    assign core_mode     = mode_q;
    assign core_go       = go_q;
    assign last_latency  = lat_q;

endmodule
